gfx_wbm_rr_arbiter: RTL and testbench

- Registered round-robin arbiter that shares the single wishbone master read/write port between NREQ gfx requesters (writer, clip, fragment, blender, textblit, flood fill).
- Replaces fixed-priority combinational selection with fair rotation, grant locking per transaction, and a timeout watchdog.
- Sits between the requesting units and the wbm reader/writer module.

---
 rtl/gfx_wbm_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_gfx_wbm_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_wbm_rr_arbiter.sv
// Round-robin arbiter that shares the wishbone master read/write port among the gfx
// requesters. The grant is held for the whole transaction, and a watchdog can force its release.
module gfx_wbm_rr_arbiter #(
   parameter int NREQ    = 6,
   parameter int MDW     = 256,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NREQ-1:0]       req_i,
   input  logic [NREQ-1:0]       we_i,
   input  logic [NREQ*32-1:0]    m_addr_i,
   input  logic [NREQ*MDW/8-1:0] m_sel_i,
   input  logic [NREQ*MDW-1:0]   m_dat_i,
   output logic [MDW-1:0]        m_dat_o,
   output logic [NREQ-1:0]       ack_o,
   output logic [NREQ-1:0]       grant_o,
   output logic                  read_request_o,
   output logic                  write_request_o,
   output logic [31:0]           addr_o,
   output logic                  we_o,
   output logic [MDW/8-1:0]      sel_o,
   output logic [MDW-1:0]        dat_o,
   input  logic [MDW-1:0]        dat_i,
   input  logic                  ack_i,
   output logic                  master_busy_o,
   output logic                  timeout_o
);

   localparam int SW = MDW / 8;
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      REL  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [IW-1:0]   last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            type_q, type_d;

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic            busy;
   logic            wd_fire;

   // Search starts just past the last served index, so the most recent winner goes last.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!pick_found && req_i[(int'(last_q) + i) % NREQ]) begin
            pick_found = 1'b1;
            pick_idx   = IW'((int'(last_q) + i) % NREQ);
         end
      end
   end

   assign busy    = (state_q == BUSY);
   assign wd_fire = (TIMEOUT != 0) && !ack_i && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      type_d  = type_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d         = '0;
               grant_d[pick_idx] = 1'b1;
               gidx_d          = pick_idx;
               type_d          = we_i[pick_idx];
               cnt_d           = '0;
               state_d         = BUSY;
            end
         end
         BUSY: begin
            cnt_d = (TIMEOUT != 0) ? cnt_q + CW'(1) : '0;
            // Ack takes precedence over the watchdog when both land in the same cycle.
            if (ack_i || wd_fire) begin
               last_d  = gidx_q;
               cnt_d   = '0;
               grant_d = '0;
               state_d = REL;
            end
         end
         REL: begin
            grant_d = '0;
            state_d = IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= IDX_LAST;
         cnt_q   <= '0;
         type_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
      end
   end

   // Data path is gated by BUSY, so nothing leaks out while idle or releasing.
   always_comb begin
      addr_o          = '0;
      sel_o           = '0;
      dat_o           = '0;
      we_o            = 1'b0;
      read_request_o  = 1'b0;
      write_request_o = 1'b0;
      ack_o           = '0;
      timeout_o       = 1'b0;
      if (busy) begin
         addr_o          = m_addr_i[int'(gidx_q)*32 +: 32];
         sel_o           = m_sel_i[int'(gidx_q)*SW +: SW];
         dat_o           = m_dat_i[int'(gidx_q)*MDW +: MDW];
         we_o            = type_q;
         read_request_o  = ~type_q;
         write_request_o = type_q;
         ack_o           = grant_q & {NREQ{ack_i}};
         timeout_o       = wd_fire;
      end
   end

   assign grant_o       = grant_q;
   assign m_dat_o       = dat_i;
   assign master_busy_o = (|req_i) || (state_q != IDLE);

endmodule

// File: tb/tb_gfx_wbm_rr_arbiter.sv
// Scoreboard bench for gfx_wbm_rr_arbiter: expected grants are queued when requests are driven
// and checked when the arbiter starts a transaction.
module tb_gfx_wbm_rr_arbiter;

   localparam int NREQ = 6;
   localparam int MDW  = 256;
   localparam int SW   = MDW / 8;
   localparam int TO   = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_i;
   logic [NREQ-1:0]       we_i;
   logic [NREQ*32-1:0]    m_addr_i;
   logic [NREQ*SW-1:0]    m_sel_i;
   logic [NREQ*MDW-1:0]   m_dat_i;
   logic [MDW-1:0]        m_dat_o;
   logic [NREQ-1:0]       ack_o;
   logic [NREQ-1:0]       grant_o;
   logic                  read_request_o;
   logic                  write_request_o;
   logic [31:0]           addr_o;
   logic                  we_o;
   logic [SW-1:0]         sel_o;
   logic [MDW-1:0]        dat_o;
   logic [MDW-1:0]        dat_i;
   logic                  ack_i;
   logic                  master_busy_o;
   logic                  timeout_o;

   typedef struct {
      logic [NREQ-1:0] grant;
      logic            we;
      logic [31:0]     addr;
      logic [SW-1:0]   sel;
      logic [MDW-1:0]  dat;
   } exp_t;

   exp_t            exp_q[$];
   exp_t            mon_e;
   logic            prev_busy = 1'b0;
   int              checks = 0;
   int              errors = 0;

   logic [31:0]     addr_tab[NREQ];
   logic [SW-1:0]   sel_tab[NREQ];
   logic [MDW-1:0]  dat_tab[NREQ];
   logic [NREQ-1:0] we_tab;
   logic [NREQ-1:0] one_hot;

   gfx_wbm_rr_arbiter #(.NREQ(NREQ), .MDW(MDW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req_i), .we_i(we_i),
      .m_addr_i(m_addr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
      .ack_o(ack_o), .grant_o(grant_o), .read_request_o(read_request_o),
      .write_request_o(write_request_o), .addr_o(addr_o), .we_o(we_o),
      .sel_o(sel_o), .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
      .master_busy_o(master_busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pack_inputs();
      for (int n = 0; n < NREQ; n++) begin
         m_addr_i[n*32 +: 32] = addr_tab[n];
         m_sel_i[n*SW +: SW]  = sel_tab[n];
         m_dat_i[n*MDW +: MDW] = dat_tab[n];
      end
      we_i = we_tab;
   endtask

   task automatic apply_stimulus(input logic [NREQ-1:0] req, input logic ack);
      req_i = req;
      ack_i = ack;
   endtask

   task automatic push_exp(input int n);
      exp_t e;
      e.grant    = '0;
      e.grant[n] = 1'b1;
      e.we       = we_tab[n];
      e.addr     = addr_tab[n];
      e.sel      = sel_tab[n];
      e.dat      = dat_tab[n];
      exp_q.push_back(e);
   endtask

   // Called at the first BUSY cycle's negedge; acks in the second BUSY cycle, checks REL, ends in IDLE.
   task automatic ack_and_release(input logic [NREQ-1:0] exp_ack, input logic [NREQ-1:0] req_after);
      tick();
      apply_stimulus(req_i, 1'b1);
      @(negedge clk);
      check_output("ack_o", ack_o, exp_ack);
      tick();
      apply_stimulus(req_after, 1'b0);
      @(negedge clk);
      check_output("rel_grant", grant_o, 0);
      check_output("rel_req", {read_request_o, write_request_o}, 0);
      check_output("rel_ack", ack_o, 0);
      tick();
   endtask

   // Scoreboard: each new transaction pops the next expected grant and payload.
   always @(negedge clk) begin
      if ((read_request_o || write_request_o) && !prev_busy) begin
         if (exp_q.size() == 0) begin
            check_output("sb_unexpected", grant_o, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("sb_grant", grant_o, mon_e.grant);
            check_output("sb_rd_wr", {read_request_o, write_request_o, we_o},
                         {~mon_e.we, mon_e.we, mon_e.we});
            check_output("sb_addr", addr_o, mon_e.addr);
            check_output("sb_sel", sel_o, mon_e.sel);
            check_output("sb_dat", dat_o, mon_e.dat);
         end
      end
      prev_busy = read_request_o || write_request_o;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      for (int n = 0; n < NREQ; n++) begin
         addr_tab[n] = 32'h1000 * (n + 1);
         sel_tab[n]  = 32'h0F0F_0000 | n;
         dat_tab[n]  = {8{32'h0101_0101 * (n + 1)}};
      end
      addr_tab[2] = 32'h0000_4000;
      sel_tab[3]  = 32'hFFFF_FFFF;
      dat_tab[3]  = {32{8'hA5}};
      we_tab      = 6'b101010;
      pack_inputs();
      dat_i = {8{32'hDEAD_BEEF}};
      apply_stimulus('0, 1'b0);
      rst = 1'b1;

      // Reset state
      tick();
      tick();
      @(negedge clk);
      check_output("rst_grant", grant_o, 0);
      check_output("rst_req", {read_request_o, write_request_o, we_o}, 0);
      check_output("rst_addr", addr_o, 0);
      check_output("rst_dat", dat_o, 0);
      check_output("rst_ack", ack_o, 0);
      check_output("rst_busy", master_busy_o, 0);
      check_output("m_dat_o", m_dat_o, {8{32'hDEAD_BEEF}});
      tick();
      rst = 1'b0;

      // Stray ack while idle
      apply_stimulus('0, 1'b1);
      @(negedge clk);
      check_output("stray_ack", ack_o, 0);
      check_output("stray_busy", master_busy_o, 0);
      tick();
      @(negedge clk);
      check_output("stray_idle", {grant_o, read_request_o, write_request_o}, 0);
      tick();
      apply_stimulus('0, 1'b0);

      // Rotation with everyone requesting
      for (int i = 0; i < 7; i++) push_exp(i % NREQ);
      apply_stimulus('1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         tick();
         @(negedge clk);
         one_hot = 6'b000001;
         ack_and_release(one_hot << (i % NREQ), (i == 6) ? 6'b000000 : 6'b111111);
      end

      // Single read to index 2
      push_exp(2);
      apply_stimulus(6'b000100, 1'b0);
      tick();
      @(negedge clk);
      check_output("rd_grant", grant_o, 6'b000100);
      check_output("rd_req", {read_request_o, write_request_o}, 2'b10);
      check_output("rd_addr", addr_o, 32'h0000_4000);
      tick();
      tick();
      tick();
      apply_stimulus(6'b000100, 1'b1);
      @(negedge clk);
      check_output("rd_ack", ack_o, 6'b000100);
      tick();
      apply_stimulus('0, 1'b0);
      @(negedge clk);
      check_output("rd_rel", {grant_o, read_request_o, write_request_o, ack_o}, 0);
      tick();
      @(negedge clk);
      check_output("rd_idle_busy", master_busy_o, 0);

      // Write from index 3
      push_exp(3);
      apply_stimulus(6'b001000, 1'b0);
      tick();
      @(negedge clk);
      check_output("wr_req", {write_request_o, we_o, read_request_o}, 3'b110);
      check_output("wr_dat", dat_o, {32{8'hA5}});
      check_output("wr_sel", sel_o, 32'hFFFF_FFFF);
      ack_and_release(6'b001000, 6'b000000);

      // Watchdog on index 1
      push_exp(1);
      apply_stimulus(6'b000010, 1'b0);
      tick();
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk);
         check_output($sformatf("to_pulse_%0d", c), timeout_o, (c == TO) ? 1'b1 : 1'b0);
         check_output("to_no_ack", ack_o, 0);
         if (c < TO) tick();
      end
      tick();
      apply_stimulus('0, 1'b0);
      @(negedge clk);
      check_output("to_rel", {grant_o, timeout_o, read_request_o, write_request_o}, 0);
      tick();
      push_exp(0);
      apply_stimulus(6'b000011, 1'b0);
      tick();
      @(negedge clk);
      ack_and_release(6'b000001, 6'b000000);

      // Reset in the middle of a grant to index 4
      push_exp(4);
      apply_stimulus(6'b010000, 1'b0);
      tick();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_output("mid_rst_out", {grant_o, read_request_o, write_request_o, we_o}, 0);
      check_output("mid_rst_addr", addr_o, 0);
      tick();
      rst = 1'b0;
      apply_stimulus('0, 1'b1);
      @(negedge clk);
      check_output("late_ack", ack_o, 0);
      check_output("late_busy", master_busy_o, 0);
      tick();
      push_exp(0);
      apply_stimulus('1, 1'b0);
      tick();
      @(negedge clk);
      ack_and_release(6'b000001, 6'b000000);

      tick();
      check_output("sb_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
